// File: rtl/and_4_2_pkg.sv
// and_4_2_pkg: shared types and the evaluation schedule for the sequential
// 4-input AND product network.
//   state_t     - sequencer states
//   step_t      - 4-bit step index, NUM_STEPS evaluation steps per operand
//   src_t       - operand selector for the shared AND gate
//   dst_t       - register written by a step
//   IDX_*       - out_data bit positions of each product term
//   step_sched  - step -> (src_a, src_b, dst) schedule
package and_4_2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_CLEAN   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int STEP_W    = 4;
  localparam int NUM_STEPS = 10;
  typedef logic [STEP_W-1:0] step_t;
  localparam step_t LAST_STEP = step_t'(NUM_STEPS - 1);

  typedef enum logic [2:0] {
    SRC_IN1 = 3'd0,
    SRC_IN2 = 3'd1,
    SRC_IN3 = 3'd2,
    SRC_IN4 = 3'd3,
    SRC_A5  = 3'd4,
    SRC_A13 = 3'd5
  } src_t;

  typedef enum logic [3:0] {
    DST_A5   = 4'd0,
    DST_A13  = 4'd1,
    DST_N7   = 4'd2,
    DST_N8   = 4'd3,
    DST_N9   = 4'd4,
    DST_N10  = 4'd5,
    DST_N11  = 4'd6,
    DST_N12  = 4'd7,
    DST_N14  = 4'd8,
    DST_N15  = 4'd9,
    DST_NONE = 4'hF
  } dst_t;

  localparam int IDX_N7  = 0;
  localparam int IDX_N8  = 1;
  localparam int IDX_N9  = 2;
  localparam int IDX_N10 = 3;
  localparam int IDX_N11 = 4;
  localparam int IDX_N12 = 5;
  localparam int IDX_N14 = 6;
  localparam int IDX_N15 = 7;

  typedef struct packed {
    src_t src_a;
    src_t src_b;
    dst_t dst;
  } sched_t;

  // The two ancillas are produced first so every later step that reuses
  // them (n7, n8, n14, n15) finds them already valid.
  function automatic sched_t step_sched(input step_t s);
    sched_t r;
    r = '{src_a: SRC_IN1, src_b: SRC_IN1, dst: DST_NONE};
    case (s)
      4'd0: r = '{src_a: SRC_IN1, src_b: SRC_IN2, dst: DST_A5};
      4'd1: r = '{src_a: SRC_IN3, src_b: SRC_IN4, dst: DST_A13};
      4'd2: r = '{src_a: SRC_A5,  src_b: SRC_A13, dst: DST_N7};
      4'd3: r = '{src_a: SRC_A5,  src_b: SRC_IN4, dst: DST_N8};
      4'd4: r = '{src_a: SRC_IN1, src_b: SRC_IN3, dst: DST_N9};
      4'd5: r = '{src_a: SRC_IN1, src_b: SRC_IN4, dst: DST_N10};
      4'd6: r = '{src_a: SRC_IN2, src_b: SRC_IN3, dst: DST_N11};
      4'd7: r = '{src_a: SRC_IN2, src_b: SRC_IN4, dst: DST_N12};
      4'd8: r = '{src_a: SRC_A13, src_b: SRC_IN1, dst: DST_N14};
      4'd9: r = '{src_a: SRC_A13, src_b: SRC_IN2, dst: DST_N15};
      default: r = '{src_a: SRC_IN1, src_b: SRC_IN1, dst: DST_NONE};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/and_term_alu.sv
// and_term_alu: the single shared 2-input AND gate with a 6:1 operand mux
// on each input. Purely combinational.
//   i_src_a/i_src_b - operand selectors (src_t encoding)
//   i_op            - latched operand {in4,in3,in2,in1}
//   i_a5/i_a13      - ancilla registers
//   o_y             - AND of the two selected operands
module and_term_alu
  import and_4_2_pkg::*;
(
  input  logic [2:0] i_src_a,
  input  logic [2:0] i_src_b,
  input  logic [3:0] i_op,
  input  logic       i_a5,
  input  logic       i_a13,
  output logic       o_y
);

  function automatic logic pick(input logic [2:0] sel, input logic [3:0] op,
                                input logic a5, input logic a13);
    logic v;
    v = 1'b0;
    case (sel)
      SRC_IN1: v = op[0];
      SRC_IN2: v = op[1];
      SRC_IN3: v = op[2];
      SRC_IN4: v = op[3];
      SRC_A5:  v = a5;
      SRC_A13: v = a13;
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  logic w_a;
  logic w_b;

  assign w_a = pick(i_src_a, i_op, i_a5, i_a13);
  assign w_b = pick(i_src_b, i_op, i_a5, i_a13);
  assign o_y = w_a & w_b;

endmodule

// File: rtl/and_4_2_seq.sv
// and_4_2_seq: time-multiplexed sequencer computing the eight product terms
// {n15,n14,n12,n11,n10,n9,n8,n7} of a 4-bit operand with one AND per cycle.
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid/in_ready   - operand handshake, in_data = {in4,in3,in2,in1}
//   out_valid/out_ready - result handshake, out_data bit 0 = n7
//   busy                - high in COMPUTE or CLEAN
//   and_ops             - saturating count of AND evaluations
//   dbg_state           - current FSM state (state_t encoding)
// Handshake rule: a transfer happens on a rising edge where valid && ready;
// valid holds with stable data until that edge, ready may depend on state
// and (in DONE only) on out_ready.
module and_4_2_seq
  import and_4_2_pkg::*;
#(
  parameter bit CLEAR_ANCILLA = 1'b1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic [CNT_W-1:0] and_ops,
  output logic [1:0]       dbg_state
);

  state_t           r_state;
  step_t            r_step;
  logic [3:0]       r_op;
  logic             r_a5;
  logic             r_a13;
  logic [7:0]       r_res;
  logic [CNT_W-1:0] r_and_ops;

  sched_t w_sched;
  logic   w_and;
  logic   w_accept;

  assign w_sched = step_sched(r_step);

  and_term_alu u_alu (
    .i_src_a (w_sched.src_a),
    .i_src_b (w_sched.src_b),
    .i_op    (r_op),
    .i_a5    (r_a5),
    .i_a13   (r_a13),
    .o_y     (w_and)
  );

  // in_ready is the only output with a combinational input dependency:
  // in DONE a new operand can enter on the same edge the result leaves.
  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_COMPUTE) || (r_state == ST_CLEAN);
  assign out_data  = r_res;
  assign and_ops   = r_and_ops;
  assign dbg_state = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_step    <= '0;
      r_op      <= '0;
      r_a5      <= 1'b0;
      r_a13     <= 1'b0;
      r_res     <= '0;
      r_and_ops <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= in_data;
            r_res   <= '0;
            r_step  <= '0;
            r_state <= ST_COMPUTE;
          end
        end

        ST_COMPUTE: begin
          case (w_sched.dst)
            DST_A5:  r_a5           <= w_and;
            DST_A13: r_a13          <= w_and;
            DST_N7:  r_res[IDX_N7]  <= w_and;
            DST_N8:  r_res[IDX_N8]  <= w_and;
            DST_N9:  r_res[IDX_N9]  <= w_and;
            DST_N10: r_res[IDX_N10] <= w_and;
            DST_N11: r_res[IDX_N11] <= w_and;
            DST_N12: r_res[IDX_N12] <= w_and;
            DST_N14: r_res[IDX_N14] <= w_and;
            DST_N15: r_res[IDX_N15] <= w_and;
            default: ;
          endcase
          if (r_and_ops != '1) begin
            r_and_ops <= r_and_ops + CNT_W'(1);
          end
          if (r_step == LAST_STEP) begin
            r_state <= CLEAR_ANCILLA ? ST_CLEAN : ST_DONE;
          end else begin
            r_step <= r_step + step_t'(1);
          end
        end

        // Uncompute the ancillas; not an AND evaluation, counter untouched.
        ST_CLEAN: begin
          r_a5    <= 1'b0;
          r_a13   <= 1'b0;
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) begin
            if (!CLEAR_ANCILLA) begin
              r_a5  <= 1'b0;
              r_a13 <= 1'b0;
            end
            if (in_valid) begin
              r_op    <= in_data;
              r_res   <= '0;
              r_step  <= '0;
              r_state <= ST_COMPUTE;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_4_2_seq.sv
// Bench for and_4_2_seq: instance dut uses CLEAR_ANCILLA=1/CNT_W=16,
// instance dut1 uses CLEAR_ANCILLA=0/CNT_W=4. sel routes stimulus to one of
// them and picks which one the monitor watches.
module tb_and_4_2_seq;
  import and_4_2_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_data;
  logic       out_ready;
  logic       sel;

  logic        in_valid0, in_ready0, out_valid0, busy0;
  logic [7:0]  out_data0;
  logic [15:0] and_ops0;
  logic [1:0]  dbg0;
  logic        in_valid1, in_ready1, out_valid1, busy1;
  logic [7:0]  out_data1;
  logic [3:0]  and_ops1;
  logic [1:0]  dbg1;

  assign in_valid0 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  and_4_2_seq #(.CLEAR_ANCILLA(1'b1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0), .busy(busy0), .and_ops(and_ops0), .dbg_state(dbg0)
  );

  and_4_2_seq #(.CLEAR_ANCILLA(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1), .busy(busy1), .and_ops(and_ops1), .dbg_state(dbg1)
  );

  logic       m_in_ready, m_out_valid;
  logic [7:0] m_out_data;
  assign m_in_ready  = sel ? in_ready1  : in_ready0;
  assign m_out_valid = sel ? out_valid1 : out_valid0;
  assign m_out_data  = sel ? out_data1  : out_data0;

  // scoreboard state
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  bit         waiting = 1'b0;
  int         exp_lat = 11;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: samples on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (waiting && m_out_valid) begin
        check("latency", 32'(cyc - acc_cyc), 32'(exp_lat));
        waiting = 1'b0;
      end
      if (m_out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", {24'h0, m_out_data}, 32'hFFFF_FFFF);
        end else begin
          check("out_data", {24'h0, m_out_data}, {24'h0, exp_q.pop_front()});
        end
      end
      if (in_valid && m_in_ready) begin
        acc_cyc = cyc + 1;
        waiting = 1'b1;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [3:0] d, input logic [7:0] e);
    bit got;
    got = 1'b0;
    exp_q.push_back(e);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (m_in_ready) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !m_out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (m_out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) check("valid_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit got;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    sel       = 1'b0;
    exp_lat   = 11;

    // reset held for two cycles
    tick();
    tick();
    check("rst_out_valid", {31'h0, out_valid0}, 32'd0);
    check("rst_out_data",  {24'h0, out_data0},  32'h00);
    check("rst_busy",      {31'h0, busy0},      32'd0);
    check("rst_and_ops",   {16'h0, and_ops0},   32'd0);
    check("rst_in_ready",  {31'h0, in_ready0},  32'd1);
    rst_n = 1'b1;
    tick();

    // all ones: every product term set
    send(4'b1111, 8'hFF);
    drain();
    check("and_ops_1", {16'h0, and_ops0}, 32'd10);

    // in4=0 leaves only n9, n11; then stall in DONE
    out_ready = 1'b0;
    send(4'b0111, 8'h14);
    wait_valid();
    check("a5_done",  {31'h0, dut.r_a5},  32'd0);
    check("a13_done", {31'h0, dut.r_a13}, 32'd0);
    exp_q.push_back(8'h20);
    in_data  = 4'b1010;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("stall_data",     {24'h0, out_data0}, 32'h14);
      check("stall_in_ready", {31'h0, in_ready0}, 32'd0);
      check("stall_valid",    {31'h0, out_valid0}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    drain();
    check("and_ops_3", {16'h0, and_ops0}, 32'd30);

    // reset while step 4 is pending
    send(4'b1111, 8'hFF);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (dut.r_step == 4'd4 && dbg0 == ST_COMPUTE) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    if (!got) check("step4_timeout", 32'd0, 32'd1);
    rst_n = 1'b0;
    tick();
    check("mid_state",     {30'h0, dbg0},       32'(ST_IDLE));
    check("mid_out_valid", {31'h0, out_valid0}, 32'd0);
    check("mid_busy",      {31'h0, busy0},      32'd0);
    check("mid_and_ops",   {16'h0, and_ops0},   32'd0);
    check("mid_out_data",  {24'h0, out_data0},  32'h00);
    check("mid_in_ready",  {31'h0, in_ready0},  32'd1);
    exp_q.delete();
    waiting = 1'b0;
    rst_n = 1'b1;
    tick();
    send(4'b1111, 8'hFF);
    drain();
    check("and_ops_post_rst", {16'h0, and_ops0}, 32'd10);

    // ancillas cleared on the handshake, 4-bit saturating counter
    sel     = 1'b1;
    exp_lat = 10;
    tick();
    send(4'b1111, 8'hFF);
    drain();
    check("sat_and_ops_1", {28'h0, and_ops1}, 32'd10);
    check("nc_a5_idle",    {31'h0, dut1.r_a5},  32'd0);
    check("nc_a13_idle",   {31'h0, dut1.r_a13}, 32'd0);
    send(4'b1111, 8'hFF);
    drain();
    check("sat_and_ops_2", {28'h0, and_ops1}, 32'd15);
    check("nc_state",      {30'h0, dbg1},     32'(ST_IDLE));
    check("nc_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
